micro_simd_seq: RTL

- Sequencer that runs one 32-bit micro-SIMD instruction over eight 4-bit lanes.
- Time-multiplexes NUM_UNITS physical 4-bit lane ALUs across all lanes.
- Collects per-lane results and flags, then returns one result word per instruction using valid/ready handshakes on both sides.
- Sits between THUMB decode/register-read and writeback for the SADD/SMUL/SSFT micro-SIMD ops.

---
 rtl/micro_simd_pkg.sv | 12 +
 rtl/simd_lane_unit.sv | 23 ++
 rtl/micro_simd_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/micro_simd_pkg.sv
// micro_simd_pkg: shared op codes, FSM states and flag indices for the micro-SIMD sequencer
package micro_simd_pkg;
  localparam int DEF_LANE_W = 4;
  localparam logic [2:0] SADD = 3'b001;
  localparam logic [2:0] SMUL = 3'b010;
  localparam logic [2:0] SSFT = 3'b011;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/simd_lane_unit.sv
// simd_lane_unit: combinational single-lane ALU (add, multiply, shift, pass-through)
module simd_lane_unit
  import micro_simd_pkg::*;
#(
  parameter int W = DEF_LANE_W
) (
  input  logic [2:0]   ctrl_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] r_o,
  output logic         c_o
);
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   shl;
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    shl  = a_i << b_i;
    r_o  = ctrl_i == SADD ? sum[W-1:0] : ctrl_i == SMUL ? prod[W-1:0] : ctrl_i == SSFT ? shl : b_i;
    c_o  = ctrl_i == SADD ? sum[W] : ctrl_i == SMUL ? prod[W] : 1'b0;
  end
endmodule

// File: rtl/micro_simd_seq.sv
// micro_simd_seq: sequences one SIMD instruction over all lanes using NUM_UNITS shared lane ALUs
module micro_simd_seq
  import micro_simd_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int LANE_W    = micro_simd_pkg::DEF_LANE_W,
  parameter int NUM_UNITS = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTn,
  input  logic                     i_VALID,
  output logic                     o_READY,
  input  logic [2:0]               i_CTRL,
  input  logic [WORD_W-1:0]        i_SRC1,
  input  logic [WORD_W-1:0]        i_SRC2,
  output logic                     o_VALID,
  input  logic                     i_READY,
  output logic [WORD_W-1:0]        o_RES,
  output logic [WORD_W/LANE_W-1:0] o_CARRY,
  output logic [3:0]               o_FLAGS
);
  localparam int LANES  = WORD_W / LANE_W;
  localparam int PASSES = LANES / NUM_UNITS;
  localparam int PW     = PASSES > 1 ? $clog2(PASSES) : 1;
  if (LANES % NUM_UNITS != 0) begin : g_bad_units
    $error("NUM_UNITS must divide the lane count");
  end
  state_e            state_q, state_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [LANES-1:0]  carry_q, carry_d;
  logic [LANE_W-1:0] ur [NUM_UNITS];
  logic [NUM_UNITS-1:0] uc;
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    simd_lane_unit #(.W(LANE_W)) u_alu (
      .ctrl_i(ctrl_q),
      .a_i   (a_q[(int'(pass_q) * NUM_UNITS + u) * LANE_W +: LANE_W]),
      .b_i   (b_q[(int'(pass_q) * NUM_UNITS + u) * LANE_W +: LANE_W]),
      .r_o   (ur[u]),
      .c_o   (uc[u])
    );
  end
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    if (state_q == IDLE && i_VALID) begin
      ctrl_d  = i_CTRL;
      a_d     = i_SRC1;
      b_d     = i_SRC2;
      res_d   = '0;
      carry_d = '0;
      pass_d  = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        res_d[(int'(pass_q) * NUM_UNITS + u) * LANE_W +: LANE_W] = ur[u];
        carry_d[int'(pass_q) * NUM_UNITS + u] = uc[u];
      end
      pass_d  = pass_q == PW'(PASSES - 1) ? '0 : pass_q + 1'b1;
      state_d = pass_q == PW'(PASSES - 1) ? DONE : RUN;
    end else if (state_q == DONE && i_READY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= IDLE;
      pass_q  <= '0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end
  assign o_READY = state_q == IDLE;
  assign o_VALID = state_q == DONE;
  assign o_RES   = res_q;
  assign o_CARRY = carry_q;
  always_comb begin
    o_FLAGS         = '0;
    o_FLAGS[FLAG_N] = res_q[WORD_W-1];
    o_FLAGS[FLAG_Z] = res_q == '0;
    o_FLAGS[FLAG_C] = |carry_q;
    o_FLAGS[FLAG_V] = 1'b0;
  end
endmodule
